exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- Exception sequencer for the single-cycle LEGv8 core.
- Takes the decoder's invalid-opcode and ERet indications plus one external level interrupt.
- Suppresses the faulting instruction, captures ELR/ESR, steers PC to the handler vector, and returns to ELR on ERet.
- Sits between the main decoder, the PC mux and the register-file/memory write enables.

Parameters:
- XLEN, 64, PC and ELR width.
- VECTOR_ADDR, 64'h00000000000000D8, handler entry address.
- CNT_W, 8, width of the exception-taken counter.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- pc  in  XLEN  PC of the instruction in execute this cycle.
- invalid_op  in  1  decoder found no matching opcode for this instruction.
- eret  in  1  decoder ERet flag for this instruction.
- irq_req  in  1  external interrupt, level, held until irq_ack.
- irq_en  in  1  interrupt enable; invalid_op is not maskable.
- kill  out  1  combinational; forces RegWrite/MemWrite/MemRead/Branch to 0 this cycle.
- pc_sel  out  2  registered; 00 = PC+4/branch, 01 = VECTOR_ADDR, 10 = elr.
- elr  out  XLEN  saved return address.
- esr  out  4  cause: 0000 none, 0001 IRQ, 0010 invalid opcode.
- irq_ack  out  1  one-cycle pulse when the IRQ is taken.
- in_handler  out  1  high in HANDLER state.
- double_fault  out  1  sticky until reset.
- exc_count  out  CNT_W  saturating count of exceptions taken.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Values on reset:
  - State = RUN.
  - pc_sel = 00.
  - elr = 0, esr = 0.
  - irq_ack = 0, double_fault = 0, exc_count = 0.
  - kill = 0 while reset is high.
- States are RUN, ENTER, HANDLER and EXIT.
- RUN:
  - take = invalid_op | (irq_req & irq_en).
  - When take is high, kill = 1 in the same cycle.
  - At the clock edge: elr <= pc; esr <= 0010 if invalid_op else 0001; exc_count += 1 (saturating at all-ones); go to ENTER.
  - invalid_op has priority over irq_req when both are high. The IRQ stays pending because it is level-held; it is taken after the return.
  - eret in RUN is illegal and is treated as invalid_op (esr = 0010).
  - pc_sel = 00.
- ENTER (exactly 1 cycle):
  - pc_sel = 01 and kill = 1.
  - irq_ack = 1 in this cycle only if esr = 0001.
  - Next state: HANDLER.
  - Exception latency is 2 cycles: the fault cycle, then the cycle in which the vector is fetched.
- HANDLER:
  - in_handler = 1, pc_sel = 00.
  - irq_req is ignored (masked).
  - eret: at the edge go to EXIT; the ERet instruction itself writes nothing, kill = 0.
  - invalid_op: kill = 1, double_fault <= 1, elr and esr are unchanged, state stays HANDLER.
  - invalid_op and eret in the same cycle: invalid_op wins, state stays HANDLER.
- EXIT (exactly 1 cycle):
  - pc_sel = 10 and kill = 1.
  - esr <= 0000 at the edge; elr holds its value.
  - Next state: RUN.
  - The instruction at elr is fetched in the following cycle.
- Reset mid-sequence (any state): back to RUN at the next edge; pc_sel and all registers return to their reset values.
- Arithmetic:
  - exc_count holds at 2^CNT_W-1 once it saturates.
  - elr is a straight copy of pc, with no offset. Both IRQ and invalid opcode re-execute the killed instruction.

Test Plan:
- invalid_op=1 at pc=0x40 in RUN -> kill=1 in the same cycle; next cycle pc_sel=01, esr=0010, elr=0x40, exc_count=1; then in_handler=1.
- irq_req=1, irq_en=1 at pc=0x80 -> ENTER with irq_ack pulsing for exactly 1 cycle, esr=0001, elr=0x80. irq_en=0 instead -> no response for 10 cycles.
- In HANDLER pulse eret -> EXIT with pc_sel=10 and elr=0x80; then RUN, pc_sel=00, esr=0000.
- invalid_op and irq_req both high -> esr=0010. After the ERet return, the IRQ is taken next: esr=0001 and exc_count=2.
- invalid_op in HANDLER -> double_fault=1, elr/esr unchanged. double_fault stays 1 across a later ERet and clears only on reset.
- Assert reset during ENTER -> next edge: state RUN, pc_sel=00, exc_count=0. Separately, with CNT_W=2, take 5 exceptions -> exc_count=3.

Source files
------------

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception sequencer for the single-cycle LEGv8 core
module exc_ctrl #(
  parameter int unsigned      XLEN        = 64,
  parameter logic [XLEN-1:0]  VECTOR_ADDR = 64'h00000000000000D8,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc,
  input  logic             invalid_op,
  input  logic             eret,
  input  logic             irq_req,
  input  logic             irq_en,
  output logic             kill,
  output logic [1:0]       pc_sel,
  output logic [XLEN-1:0]  elr,
  output logic [3:0]       esr,
  output logic             irq_ack,
  output logic             in_handler,
  output logic             double_fault,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_EXIT    = 2'd3
  } state_t;

  localparam logic [3:0] ESR_NONE = 4'b0000;
  localparam logic [3:0] ESR_IRQ  = 4'b0001;
  localparam logic [3:0] ESR_INV  = 4'b0010;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_VEC = 2'b01;
  localparam logic [1:0] SEL_ELR = 2'b10;

  state_t     state;
  state_t     state_nxt;
  logic       bad_op;
  logic       take;
  logic [1:0] pc_sel_nxt;

  // The vector address itself is selected by the PC mux outside this block;
  // this controller only drives the select code.
  logic unused_vec;
  assign unused_vec = ^VECTOR_ADDR;

  // ERet outside a handler has no saved context, so it faults like an
  // undefined opcode.
  assign bad_op = invalid_op | eret;
  assign take   = bad_op | (irq_req & irq_en);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (take) begin
          state_nxt = ST_ENTER;
        end
      end
      ST_ENTER: begin
        state_nxt = ST_HANDLER;
      end
      ST_HANDLER: begin
        // A fault inside the handler wins over a simultaneous ERet.
        if (eret && !invalid_op) begin
          state_nxt = ST_EXIT;
        end
      end
      ST_EXIT: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Combinational outputs and the select code for the coming state.
  always_comb begin
    kill       = 1'b0;
    irq_ack    = 1'b0;
    in_handler = 1'b0;
    pc_sel_nxt = SEL_SEQ;
    case (state)
      ST_RUN: begin
        kill = take;
      end
      ST_ENTER: begin
        kill    = 1'b1;
        irq_ack = (esr == ESR_IRQ);
      end
      ST_HANDLER: begin
        in_handler = 1'b1;
        kill       = invalid_op;
      end
      ST_EXIT: begin
        kill = 1'b1;
      end
      default: begin
        kill = 1'b0;
      end
    endcase
    case (state_nxt)
      ST_ENTER: pc_sel_nxt = SEL_VEC;
      ST_EXIT:  pc_sel_nxt = SEL_ELR;
      default:  pc_sel_nxt = SEL_SEQ;
    endcase
    if (reset) begin
      kill    = 1'b0;
      irq_ack = 1'b0;
    end
  end

  // Exception context: return address, cause, counters and the PC select.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_sel       <= SEL_SEQ;
      elr          <= '0;
      esr          <= ESR_NONE;
      double_fault <= 1'b0;
      exc_count    <= '0;
    end else begin
      pc_sel <= pc_sel_nxt;
      case (state)
        ST_RUN: begin
          if (take) begin
            // The killed instruction is re-executed, so no PC offset.
            elr <= pc;
            esr <= bad_op ? ESR_INV : ESR_IRQ;
            if (exc_count != {CNT_W{1'b1}}) begin
              exc_count <= exc_count + 1'b1;
            end
          end
        end
        ST_HANDLER: begin
          if (invalid_op) begin
            double_fault <= 1'b1;
          end
        end
        ST_EXIT: begin
          esr <= ESR_NONE;
        end
        default: begin
          esr <= esr;
        end
      endcase
    end
  end

endmodule
